// File: rtl/trace_pkg.sv
// trace_pkg: shared width encodings, packer state enum and width-to-k mapping.
package trace_pkg;
  localparam logic [1:0] TW_1BIT = 2'd0;
  localparam logic [1:0] TW_2BIT = 2'd1;
  localparam logic [1:0] TW_4BIT = 2'd2;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPTURE, EMIT} pack_state_t;
  function automatic logic [2:0] widthToK(input logic [1:0] w);
    return (w == TW_1BIT) ? 3'd1 : (w == TW_2BIT) ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/trace_bit_packer.sv
// trace_bit_packer: LSB-first shift register of k-bit samples; full flags that the current load completes the byte.
module trace_bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] k,
  input  logic [3:0] din,
  input  logic       clear,
  output logic [7:0] byteVal,
  output logic       full,
  output logic       empty
);
  logic [3:0] bitCnt;
  logic [3:0] mask;
  logic [7:0] ins;
  always_comb begin
    mask = (k == 3'd1) ? 4'h1 : (k == 3'd2) ? 4'h3 : 4'hF;
    ins = {4'b0, din & mask} << bitCnt;
    full = (bitCnt + {1'b0, k}) == 4'd8;
    empty = bitCnt == 4'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      byteVal <= 8'h00;
      bitCnt <= 4'd0;
    end else if (clear) begin
      byteVal <= 8'h00;
      bitCnt <= 4'd0;
    end else if (load) begin
      byteVal <= byteVal | ins;
      bitCnt <= bitCnt + {1'b0, k};
    end
endmodule

// File: rtl/trace_pack_ctrl.sv
// trace_pack_ctrl: fetch sequencer and byte handshake for the trace bit packer.
// Optional TRACE_PACK_STATS_EN adds a saturating byteCount of accepted bytes.
module trace_pack_ctrl
  import trace_pkg::*;
#(
  parameter int MAX_BUS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [1:0]               width,
  input  logic                     dAvail,
  input  logic [MAX_BUS_WIDTH-1:0] dIn,
  input  logic                     byteReady,
  output logic                     dNext,
  output logic [7:0]               byteOut,
  output logic                     byteValid
`ifdef TRACE_PACK_STATS_EN
  ,
  output logic [15:0]              byteCount
`endif
);
  pack_state_t state;
  logic [2:0] kLat;
  logic load, clear, full, empty;
  assign load = state == CAPTURE;
  assign clear = (state == IDLE && !enable) || (state == EMIT && byteReady);
  trace_bit_packer u_packer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .k(kLat),
    .din(dIn[3:0]),
    .clear(clear),
    .byteVal(byteOut),
    .full(full),
    .empty(empty)
  );
  // Width only moves at a byte boundary so a byte never mixes sample sizes.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      dNext <= 1'b0;
      byteValid <= 1'b0;
      kLat <= 3'd1;
    end else begin
      case (state)
        IDLE: begin
          if (empty) kLat <= widthToK(width);
          if (enable && dAvail) begin
            state <= REQ;
            dNext <= 1'b1;
          end
        end
        REQ: begin
          dNext <= 1'b0;
          state <= WAIT;
        end
        WAIT: state <= CAPTURE;
        CAPTURE: begin
          state <= full ? EMIT : IDLE;
          byteValid <= full;
        end
        EMIT: if (byteReady) begin
          byteValid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef TRACE_PACK_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) byteCount <= 16'd0;
    else if (byteValid && byteReady && byteCount != 16'hFFFF) byteCount <= byteCount + 16'd1;
`endif
endmodule

// File: tb/tb_trace_pack_ctrl.sv
// tb_trace_pack_ctrl: directed stimulus with a byte scoreboard and a capture buffer model.
module tb_trace_pack_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic [1:0] width = 2'd2;
  logic dAvail = 1'b0;
  logic [3:0] dIn = 4'h0;
  logic byteReady = 1'b1;
  logic dNext;
  logic [7:0] byteOut;
  logic byteValid;
`ifdef TRACE_PACK_STATS_EN
  logic [15:0] byteCount;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int lastPulse = -1;
  int firstPulse = -1;
  int firstValid = -1;
  logic prevDn = 1'b0;
  logic [3:0] bufQ[$];
  logic [7:0] expQ[$];

  trace_pack_ctrl #(.MAX_BUS_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .width(width),
    .dAvail(dAvail),
    .dIn(dIn),
    .byteReady(byteReady),
    .dNext(dNext),
    .byteOut(byteOut),
    .byteValid(byteValid)
`ifdef TRACE_PACK_STATS_EN
    ,
    .byteCount(byteCount)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) dAvail <= bufQ.size() != 0;
  always @(posedge dNext) if (bufQ.size() != 0) dIn = bufQ.pop_front();

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (dNext) begin
      if (prevDn) check("dnext_consecutive", 1, 0);
      pulses++;
      lastPulse = cyc;
      if (firstPulse < 0) firstPulse = cyc;
    end
    prevDn = dNext;
    if (byteValid && firstValid < 0) firstValid = cyc;
    if (byteValid && byteReady) begin
      if (expQ.size() == 0) check("unexpected_byte", int'(byteOut), -1);
      else check("byte", int'(byteOut), int'(expQ.pop_front()));
    end
  end

  task automatic push(input logic [3:0] s);
    bufQ.push_back(s);
  endtask

  task automatic drain(input string name, input int tail);
    int n = 0;
    while ((expQ.size() != 0 || bufQ.size() != 0) && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (n >= 600) check({name, "_timeout"}, n, 0);
    repeat (tail) @(posedge clk);
    #1;
  endtask

  initial begin
    int rel, p0, c0, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dnext", int'(dNext), 0);
    check("rst_valid", int'(byteValid), 0);
    check("rst_byte", int'(byteOut), 0);
    // 4-bit: cycle 0 is the first IDLE after release
    push(4'h5); push(4'hA); expQ.push_back(8'hA5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
    drain("t1", 4);
    check("t1_first_dnext_cycle", firstPulse - rel, 1);
    check("t1_first_valid_cycle", firstValid - rel, 8);
    check("t1_pulses", pulses, 2);
    // 1-bit
    width = 2'd0;
    p0 = pulses;
    push(1); push(0); push(1); push(1); push(0); push(0); push(0); push(1);
    expQ.push_back(8'h8D);
    drain("t2", 4);
    check("t2_pulses", pulses - p0, 8);
    // 2-bit, width change mid-byte is deferred
    width = 2'd1;
    repeat (2) @(posedge clk);
    push(3); push(0);
    drain("t3a", 6);
    width = 2'd2;
    push(1); push(2); push(6); push(7);
    expQ.push_back(8'h93); expQ.push_back(8'h76);
    drain("t3b", 4);
    // backpressure
    byteReady = 1'b0;
    push(1); push(2); push(3); push(4);
    expQ.push_back(8'h21); expQ.push_back(8'h43);
    n = 0;
    while (!byteValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_valid_seen", int'(byteValid), 1);
    p0 = pulses;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("t4_hold_valid", int'(byteValid), 1);
      check("t4_hold_byte", int'(byteOut), 8'h21);
    end
    check("t4_no_fetch", pulses - p0, 0);
    @(posedge clk);
    #1;
    byteReady = 1'b1;
    c0 = cyc;
    n = 0;
    while (pulses == p0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_next_fetch_cycle", lastPulse - c0, 2);
    drain("t4", 4);
    // empty buffer, then disable with a partial byte pending
    p0 = pulses;
    push(4'h9);
    repeat (12) @(posedge clk);
    #1;
    check("t5_one_fetch", pulses - p0, 1);
    check("t5_idle_dnext", int'(dNext), 0);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    push(4'h3); push(4'hC); expQ.push_back(8'hC3);
    repeat (8) @(posedge clk);
    #1;
    check("t5_disabled_no_fetch", pulses - p0, 1);
    check("t5_partial_discarded", int'(byteOut), 0);
    enable = 1'b1;
    drain("t5", 4);
    // async reset during WAIT
    p0 = pulses;
    push(4'h7); push(4'h1);
    n = 0;
    while (pulses < p0 + 2 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t6_second_fetch", pulses - p0, 2);
    @(posedge clk);
    #2;
    check("t6_partial_before_rst", int'(byteOut), 8'h07);
    rst = 1'b1;
    #1;
    check("t6_rst_dnext", int'(dNext), 0);
    check("t6_rst_valid", int'(byteValid), 0);
    check("t6_rst_byte", int'(byteOut), 0);
`ifdef TRACE_PACK_STATS_EN
    check("t6_rst_count", int'(byteCount), 0);
`endif
    bufQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(1); push(2); push(3); push(4); push(5); push(6);
    expQ.push_back(8'h21); expQ.push_back(8'h43); expQ.push_back(8'h65);
    drain("t7", 4);
`ifdef TRACE_PACK_STATS_EN
    check("t7_count", int'(byteCount), 3);
    rst = 1'b1;
    #1;
    check("t7_count_rst", int'(byteCount), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif
    check("exp_queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
